// File: rtl/alu_pkg.sv
// Shared opcode values and FSM state encoding for the multicycle ALU.
// Imported by alu_multicycle and alu_iter_muldiv.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIVU = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_SLT  = 4'b1110;
  localparam logic [3:0] OP_EQ   = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_legal(input logic [3:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIVU, OP_SLL, OP_SRA, OP_SRL,
      OP_NAND, OP_SLT, OP_EQ: legal = 1'b1;
      default:                legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider sharing one accumulator.
// Loads on start, runs WIDTH iterations, result is {hi,lo} = {acc,quo}.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] operand;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             div_q;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;

  // The remainder stays below the divisor, so the top bit of div_diff is a pure borrow.
  always_comb begin
    mul_sum   = {1'b0, acc} + (quo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    div_shift = {acc, quo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, operand};
  end

  assign last = busy && (cnt == CNT_W'(WIDTH-1));
  assign lo   = quo;
  assign hi   = acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      quo     <= '0;
      operand <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      div_q   <= 1'b0;
    end else if (start) begin
      acc     <= '0;
      quo     <= a;
      operand <= b;
      cnt     <= '0;
      busy    <= 1'b1;
      div_q   <= is_div;
    end else if (busy) begin
      if (div_q) begin
        if (!div_diff[WIDTH]) begin
          acc <= div_diff[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b1};
        end else begin
          acc <= div_shift[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b0};
        end
      end else begin
        {acc, quo} <= {mul_sum, quo[WIDTH-1:1]};
      end
      cnt <= cnt + CNT_W'(1);
      if (last) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Handshaked ALU: single-cycle ops plus iterative MUL/DIVU, with result held until consumed.
// Results are captured one edge after entering DONE, which is when out_valid rises.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_OP,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] HI,
  output logic             overflow,
  output logic             zero_flag,
  output logic             div_zero,
  output logic             illegal_op
);

  state_t state, state_next;

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [3:0]         op_q;
  logic               init_done;
  logic               accept;
  logic               iter_in;
  logic               md_last;
  logic [WIDTH-1:0]   md_lo;
  logic [WIDTH-1:0]   md_hi;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic               ov_add;
  logic               ov_sub;
  logic [SHAMT_W-1:0] shamt;
  logic               shamt_big;
  logic [WIDTH-1:0]   res_lo;
  logic [WIDTH-1:0]   res_hi;
  logic               res_ov;
  logic               res_zf;
  logic               res_dz;
  logic               res_il;

  assign in_ready = init_done && (state == S_IDLE);
  assign accept   = in_valid && in_ready;
  assign iter_in  = (ALU_OP == OP_MUL) || ((ALU_OP == OP_DIVU) && (B != '0));

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && iter_in),
    .is_div (ALU_OP == OP_DIVU),
    .a      (A),
    .b      (B),
    .last   (md_last),
    .lo     (md_lo),
    .hi     (md_hi)
  );

  // in_ready stays low until the first edge after reset is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      init_done <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
    end else begin
      state     <= state_next;
      init_done <= 1'b1;
      if (accept) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= ALU_OP;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = iter_in ? S_BUSY : S_DONE;
      S_BUSY: if (md_last) state_next = S_DONE;
      S_DONE: if (out_valid && out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    sum       = a_q + b_q;
    diff      = a_q - b_q;
    ov_add    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
    ov_sub    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
    shamt     = b_q[SHAMT_W-1:0];
    shamt_big = (int'(shamt) >= WIDTH);
  end

  // Single-cycle results, or the iterative unit's result once it has finished.
  always_comb begin
    res_lo = '0;
    res_hi = '0;
    res_ov = 1'b0;
    res_dz = 1'b0;
    res_il = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_lo = sum;
        res_ov = ov_add;
      end
      OP_SUB: begin
        res_lo = diff;
        res_ov = ov_sub;
      end
      OP_MUL: begin
        res_lo = md_lo;
        res_hi = md_hi;
      end
      OP_DIVU: begin
        if (b_q == '0) begin
          res_lo = '1;
          res_hi = a_q;
          res_dz = 1'b1;
        end else begin
          res_lo = md_lo;
          res_hi = md_hi;
        end
      end
      OP_SLL:  res_lo = shamt_big ? '0 : (a_q << shamt);
      OP_SRA:  res_lo = shamt_big ? {WIDTH{a_q[WIDTH-1]}} : WIDTH'($signed(a_q) >>> shamt);
      OP_SRL:  res_lo = shamt_big ? '0 : (a_q >> shamt);
      OP_NAND: res_lo = ~(a_q & b_q);
      OP_SLT: begin
        res_lo = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ ov_sub};
        res_ov = ov_sub;
      end
      OP_EQ:   res_lo = {{(WIDTH-1){1'b0}}, (a_q == b_q)};
      default: res_il = 1'b1;
    endcase
    res_zf = !res_il && (res_lo == '0) && ((op_q != OP_MUL) || (res_hi == '0));
  end

  // Results are never cleared by the handshake, only replaced by the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      LO         <= '0;
      HI         <= '0;
      overflow   <= 1'b0;
      zero_flag  <= 1'b0;
      div_zero   <= 1'b0;
      illegal_op <= 1'b0;
    end else if ((state == S_DONE) && !out_valid) begin
      out_valid  <= 1'b1;
      LO         <= res_lo;
      HI         <= res_hi;
      overflow   <= res_ov;
      zero_flag  <= res_zf;
      div_zero   <= res_dz;
      illegal_op <= res_il;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomised and directed bench for alu_multicycle (WIDTH=8, plus a WIDTH=16 instance).
module tb_alu_multicycle;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  A = '0;
  logic [7:0]  B = '0;
  logic [3:0]  ALU_OP = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  LO, HI;
  logic        overflow, zero_flag, div_zero, illegal_op;

  logic        in_valid16 = 1'b0;
  logic        in_ready16;
  logic [15:0] A16 = '0;
  logic [15:0] B16 = '0;
  logic [3:0]  op16 = '0;
  logic        out_valid16;
  logic        out_ready16 = 1'b0;
  logic [15:0] LO16, HI16;
  logic        ov16, zf16, dz16, il16;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALU_OP(ALU_OP), .out_valid(out_valid), .out_ready(out_ready),
    .LO(LO), .HI(HI), .overflow(overflow), .zero_flag(zero_flag),
    .div_zero(div_zero), .illegal_op(illegal_op)
  );

  alu_multicycle #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .A(A16), .B(B16), .ALU_OP(op16), .out_valid(out_valid16), .out_ready(out_ready16),
    .LO(LO16), .HI(HI16), .overflow(ov16), .zero_flag(zf16),
    .div_zero(dz16), .illegal_op(il16)
  );

  // Reference: {lo, hi, overflow, zero, div_zero, illegal} from integer arithmetic.
  function automatic logic [19:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int ua, ub, sa, sb, r, amt;
    logic [7:0] lo, hi;
    logic ov, zf, dz, il;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    amt = ub % 16;
    lo = '0; hi = '0; ov = 1'b0; dz = 1'b0; il = 1'b0; r = 0;
    case (op)
      4'd0: begin r = ua + ub; lo = r[7:0]; ov = (sa + sb > 127) || (sa + sb < -128); end
      4'd1: begin r = ua - ub; lo = r[7:0]; ov = (sa - sb > 127) || (sa - sb < -128); end
      4'd2: begin r = ua * ub; lo = r[7:0]; hi = r[15:8]; end
      4'd3: begin
        if (ub == 0) begin lo = 8'hFF; hi = a; dz = 1'b1; end
        else begin r = ua / ub; lo = r[7:0]; r = ua % ub; hi = r[7:0]; end
      end
      4'd4: begin r = (amt >= 8) ? 0 : (ua << amt); lo = r[7:0]; end
      4'd5: begin r = sa >>> ((amt >= 8) ? 7 : amt); lo = r[7:0]; end
      4'd6: begin r = (amt >= 8) ? 0 : (ua >> amt); lo = r[7:0]; end
      4'd12: begin r = ~(ua & ub); lo = r[7:0]; end
      4'd14: begin lo = (sa < sb) ? 8'd1 : 8'd0; ov = (sa - sb > 127) || (sa - sb < -128); end
      4'd15: lo = (ua == ub) ? 8'd1 : 8'd0;
      default: il = 1'b1;
    endcase
    zf = !il && (lo == '0) && ((op != 4'd2) || (hi == '0));
    return {lo, hi, ov, zf, dz, il};
  endfunction

  // Issue one op on the 8-bit DUT; returns edges from accept to out_valid.
  task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       output int lat, output bit saw_ready);
    int guard = 0;
    while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    if (!in_ready) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL in_ready_timeout: got %b expected 1", in_ready);
    end
    ALU_OP = op; A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; A = 8'($urandom); B = 8'($urandom); ALU_OP = 4'($urandom);
    lat = 0; saw_ready = 1'b0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
      if (in_ready) saw_ready = 1'b1;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
    tests_run++; if ({out_valid, LO, HI, overflow, zero_flag, div_zero, illegal_op} !== 21'd0) begin tests_failed++;
      $display("[TB] FAIL reset_outputs: got %b %h %h %b%b%b%b expected all zero", out_valid, LO, HI, overflow, zero_flag, div_zero, illegal_op); end
    rst = 1'b1;
    #1;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL release_in_ready_early: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_add_sub();
    int lat; bit sr;
    do_op(4'd0, 8'h7F, 8'h01, lat, sr);
    tests_run++; if ({LO, overflow} !== {8'h80, 1'b1}) begin tests_failed++; $display("[TB] FAIL add_ovf: got %h ov=%b expected 80 ov=1", LO, overflow); end
    tests_run++; if (lat !== 1) begin tests_failed++; $display("[TB] FAIL add_latency: got %0d expected 1", lat); end
    finish_op();
    do_op(4'd1, 8'd5, 8'd5, lat, sr);
    tests_run++; if ({LO, zero_flag, overflow} !== {8'h00, 1'b1, 1'b0}) begin tests_failed++; $display("[TB] FAIL sub_zero: got %h zf=%b ov=%b expected 00 zf=1 ov=0", LO, zero_flag, overflow); end
    finish_op();
  endtask

  task automatic test_mul();
    int lat; bit sr;
    do_op(4'd2, 8'hFF, 8'hFF, lat, sr);
    tests_run++; if ({HI, LO} !== 16'hFE01) begin tests_failed++; $display("[TB] FAIL mul_ff: got %h%h expected fe01", HI, LO); end
    tests_run++; if (lat !== 9) begin tests_failed++; $display("[TB] FAIL mul_latency: got %0d expected 9", lat); end
    tests_run++; if (sr !== 1'b0) begin tests_failed++; $display("[TB] FAIL mul_in_ready: got %b expected 0 throughout", sr); end
    finish_op();
  endtask

  task automatic test_div();
    int lat; bit sr;
    do_op(4'd3, 8'd200, 8'd7, lat, sr);
    tests_run++; if ({LO, HI, div_zero} !== {8'd28, 8'd4, 1'b0}) begin tests_failed++; $display("[TB] FAIL div_200_7: got q=%0d r=%0d dz=%b expected 28 4 0", LO, HI, div_zero); end
    tests_run++; if (lat !== 9) begin tests_failed++; $display("[TB] FAIL div_latency: got %0d expected 9", lat); end
    finish_op();
    do_op(4'd3, 8'd9, 8'd0, lat, sr);
    tests_run++; if ({LO, HI, div_zero} !== {8'hFF, 8'd9, 1'b1}) begin tests_failed++; $display("[TB] FAIL div_zero: got %h %h dz=%b expected ff 09 1", LO, HI, div_zero); end
    tests_run++; if (lat !== 1) begin tests_failed++; $display("[TB] FAIL div_zero_latency: got %0d expected 1", lat); end
    finish_op();
  endtask

  task automatic test_shifts();
    logic [3:0] ops [4] = '{4'd5, 4'd5, 4'd4, 4'd6};
    logic [7:0] as  [4] = '{8'h90, 8'h90, 8'h81, 8'h90};
    logic [7:0] bs  [4] = '{8'd3, 8'd12, 8'd8, 8'd4};
    logic [7:0] exp [4] = '{8'hF2, 8'hFF, 8'h00, 8'h09};
    int lat; bit sr;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], as[i], bs[i], lat, sr);
      tests_run++; if ({LO, HI} !== {exp[i], 8'h00}) begin tests_failed++; $display("[TB] FAIL shift_%0d: got %h/%h expected %h/00", i, LO, HI, exp[i]); end
      finish_op();
    end
  endtask

  task automatic test_back_pressure();
    int lat; bit sr; int bad = 0;
    do_op(4'd14, 8'hFD, 8'h02, lat, sr);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!(out_valid === 1'b1 && LO === 8'd1 && in_ready === 1'b0)) bad++;
    end
    tests_run++; if (bad !== 0) begin tests_failed++; $display("[TB] FAIL backpressure_hold: got %0d bad cycles expected 0 (LO=%h ov=%b)", bad, LO, out_valid); end
    finish_op();
    tests_run++; if ({in_ready, out_valid, LO} !== {1'b1, 1'b0, 8'd1}) begin tests_failed++; $display("[TB] FAIL backpressure_release: got rdy=%b vld=%b LO=%h expected 1 0 01", in_ready, out_valid, LO); end
  endtask

  task automatic test_back_to_back();
    int lat; bit sr; logic [19:0] exp;
    for (int i = 0; i < 3; i++) begin
      exp = model(4'd0, 8'(i * 40), 8'd17);
      do_op(4'd0, 8'(i * 40), 8'd17, lat, sr);
      tests_run++; if ({LO, HI, overflow, zero_flag, div_zero, illegal_op} !== exp) begin tests_failed++; $display("[TB] FAIL b2b_%0d: got %h expected %h", i, {LO, HI, overflow, zero_flag, div_zero, illegal_op}, exp); end
      finish_op();
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_ready_%0d: got %b expected 1", i, in_ready); end
    end
  endtask

  task automatic test_reset_mid_mul();
    int lat; bit sr; int seen = 0;
    do_op(4'd2, 8'h12, 8'h34, lat, sr);
    finish_op();
    ALU_OP = 4'd2; A = 8'hAB; B = 8'hCD; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    tests_run++; if ({out_valid, LO, HI} !== 17'd0) begin tests_failed++; $display("[TB] FAIL reset_mid_mul: got vld=%b LO=%h HI=%h expected 0 00 00", out_valid, LO, HI); end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (20) begin @(posedge clk); #1; if (out_valid) seen++; end
    tests_run++; if (seen !== 0) begin tests_failed++; $display("[TB] FAIL reset_no_result: got %0d valid cycles expected 0", seen); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_idle: got %b expected 1", in_ready); end
  endtask

  task automatic test_random();
    int lat; bit sr; logic [19:0] exp;
    logic [3:0] op; logic [7:0] a, b;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      exp = model(op, a, b);
      do_op(op, a, b, lat, sr);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      tests_run++; if ({LO, HI, overflow, zero_flag, div_zero, illegal_op} !== exp) begin tests_failed++;
        $display("[TB] FAIL random_%0d op=%h a=%h b=%h: got %h expected %h", i, op, a, b, {LO, HI, overflow, zero_flag, div_zero, illegal_op}, exp); end
      tests_run++; if (lat !== (((op == 4'd2) || (op == 4'd3 && b != 8'd0)) ? 9 : 1)) begin tests_failed++;
        $display("[TB] FAIL random_lat_%0d op=%h: got %0d", i, op, lat); end
      finish_op();
    end
  endtask

  task automatic test_width16();
    int lat = 0; int guard = 0;
    while (!in_ready16 && guard < 50) begin @(posedge clk); #1; guard++; end
    op16 = 4'd2; A16 = 16'hFFFF; B16 = 16'h0002; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    while (!out_valid16 && lat < 60) begin @(posedge clk); #1; lat++; end
    tests_run++; if ({HI16, LO16} !== 32'h0001_FFFE) begin tests_failed++; $display("[TB] FAIL w16_mul: got %h%h expected 0001fffe", HI16, LO16); end
    tests_run++; if (lat !== 17) begin tests_failed++; $display("[TB] FAIL w16_latency: got %0d expected 17", lat); end
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_div();
    test_shifts();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid_mul();
    test_random();
    test_width16();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
